// File: rtl/dual_mem_stage.sv
// Dual-issue memory stage: EX/MEM register, shared single-port word memory, MEM/WB register.
// Latency: E->M one edge, M->W next edge; a pair with two memory ops adds one cycle.
// Backpressure: stallm asserts for one cycle when both M lanes access memory; E inputs ignored then.
//
// Ports: clk/reset (sync, active-high); E-stage lane inputs (regwritee*, memtorege*, memwritee*,
// solutione*, writedatae*, writerege*); M-stage forwarding outputs (aluoutm*, writeregm*,
// regwritem*); stallm; W-stage outputs (resultw*, writeregw*, regwritew*); sticky memerr.
module dual_mem_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwritee,
    input  logic        regwritee2,
    input  logic        memtorege,
    input  logic        memtorege2,
    input  logic        memwritee,
    input  logic        memwritee2,
    input  logic [31:0] solutione,
    input  logic [31:0] solutione2,
    input  logic [31:0] writedatae,
    input  logic [31:0] writedatae2,
    input  logic [4:0]  writerege,
    input  logic [4:0]  writerege2,
    output logic [31:0] aluoutm,
    output logic [31:0] aluoutm2,
    output logic [4:0]  writeregm,
    output logic [4:0]  writeregm2,
    output logic        regwritem,
    output logic        regwritem2,
    output logic        stallm,
    output logic [31:0] resultw,
    output logic [31:0] resultw2,
    output logic [4:0]  writeregw,
    output logic [4:0]  writeregw2,
    output logic        regwritew,
    output logic        regwritew2,
    output logic        memerr
);

    typedef enum logic {NORMAL = 1'b0, SECOND = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // EX/MEM register
    logic        r_regwritem, r_regwritem2;
    logic        r_memtoregm, r_memtoregm2;
    logic        r_memwritem, r_memwritem2;
    logic [31:0] r_aluoutm, r_aluoutm2;
    logic [31:0] r_writedatam, r_writedatam2;
    logic [4:0]  r_writeregm, r_writeregm2;

    // MEM/WB register
    logic [31:0] r_resultw, r_resultw2;
    logic [4:0]  r_writeregw, r_writeregw2;
    logic        r_regwritew, r_regwritew2;

    logic [31:0] r_hold;     // lane-1 load data parked while lane 2 takes its slot
    logic        r_memerr;
    logic [31:0] r_mem [DEPTH];

    logic          w_memop1, w_memop2;
    logic          w_stall;
    logic          w_acc;    // a memory access occupies this cycle's slot
    logic          w_sel2;   // the slot belongs to lane 2
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lo;
    logic          w_is_store;
    logic [31:0]   w_wdata;
    logic          w_misal;
    logic          w_we;
    logic [31:0]   w_ld;
    logic [31:0]   w_res1, w_res2;

    assign w_memop1 = r_memtoregm  | r_memwritem;
    assign w_memop2 = r_memtoregm2 | r_memwritem2;

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_acc       = 1'b0;
        w_sel2      = 1'b0;
        case (r_state)
            NORMAL: begin
                w_acc  = w_memop1 | w_memop2;
                w_sel2 = ~w_memop1;
                if (w_memop1 && w_memop2) begin
                    w_stall     = 1'b1;
                    w_state_nxt = SECOND;
                end
            end
            SECOND: begin
                w_acc       = w_memop2;
                w_sel2      = 1'b1;
                w_state_nxt = NORMAL;
            end
            default: w_state_nxt = NORMAL;
        endcase
    end

    assign w_idx      = w_sel2 ? r_aluoutm2[AW+1:2] : r_aluoutm[AW+1:2];
    assign w_lo       = w_sel2 ? r_aluoutm2[1:0]    : r_aluoutm[1:0];
    assign w_is_store = w_sel2 ? r_memwritem2       : r_memwritem;
    assign w_wdata    = w_sel2 ? r_writedatam2      : r_writedatam;
    assign w_misal    = w_acc & (w_lo != 2'b00);
    // Reset gates the write so a lane-2 store pending in SECOND is dropped.
    assign w_we       = w_acc & w_is_store & ~w_misal & ~reset;
    assign w_ld       = w_misal ? 32'h0 : r_mem[w_idx];

    // In SECOND lane-1 load data comes from the hold register, lane 2 from the live read.
    assign w_res1 = r_memtoregm  ? ((r_state == SECOND) ? r_hold : w_ld) : r_aluoutm;
    assign w_res2 = r_memtoregm2 ? w_ld : r_aluoutm2;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= NORMAL;
            r_regwritem   <= 1'b0;
            r_regwritem2  <= 1'b0;
            r_memtoregm   <= 1'b0;
            r_memtoregm2  <= 1'b0;
            r_memwritem   <= 1'b0;
            r_memwritem2  <= 1'b0;
            r_aluoutm     <= 32'h0;
            r_aluoutm2    <= 32'h0;
            r_writedatam  <= 32'h0;
            r_writedatam2 <= 32'h0;
            r_writeregm   <= 5'h0;
            r_writeregm2  <= 5'h0;
            r_resultw     <= 32'h0;
            r_resultw2    <= 32'h0;
            r_writeregw   <= 5'h0;
            r_writeregw2  <= 5'h0;
            r_regwritew   <= 1'b0;
            r_regwritew2  <= 1'b0;
            r_hold        <= 32'h0;
            r_memerr      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_misal) begin
                r_memerr <= 1'b1;
            end
            if (w_stall) begin
                // First half of a conflicting pair: M holds, W gets a bubble.
                r_hold       <= w_ld;
                r_regwritew  <= 1'b0;
                r_regwritew2 <= 1'b0;
            end else begin
                r_resultw     <= w_res1;
                r_resultw2    <= w_res2;
                r_writeregw   <= r_writeregm;
                r_writeregw2  <= r_writeregm2;
                r_regwritew   <= r_regwritem;
                r_regwritew2  <= r_regwritem2;
                r_regwritem   <= regwritee;
                r_regwritem2  <= regwritee2;
                r_memtoregm   <= memtorege;
                r_memtoregm2  <= memtorege2;
                r_memwritem   <= memwritee;
                r_memwritem2  <= memwritee2;
                r_aluoutm     <= solutione;
                r_aluoutm2    <= solutione2;
                r_writedatam  <= writedatae;
                r_writedatam2 <= writedatae2;
                r_writeregm   <= writerege;
                r_writeregm2  <= writerege2;
            end
        end
    end

    assign aluoutm    = r_aluoutm;
    assign aluoutm2   = r_aluoutm2;
    assign writeregm  = r_writeregm;
    assign writeregm2 = r_writeregm2;
    assign regwritem  = r_regwritem;
    assign regwritem2 = r_regwritem2;
    assign stallm     = w_stall;
    assign resultw    = r_resultw;
    assign resultw2   = r_resultw2;
    assign writeregw  = r_writeregw;
    assign writeregw2 = r_writeregw2;
    assign regwritew  = r_regwritew;
    assign regwritew2 = r_regwritew2;
    assign memerr     = r_memerr;

endmodule
